// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller for a word-addressed RAM with registered read.
// Sub-word stores are read-modify-write; optional range check enabled by MAU_RANGE_CHECK_EN.
module mem_access_unit #(
    parameter int RAM_ADDR_WIDTH = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall_out,
    output logic        done,
    output logic [31:0] rdata_out,
    output logic        misaligned_exc,
    output logic        access_fault,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    input  logic        mem_stall
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_done;
    logic [31:0] r_rdata;
    logic        r_misaligned_exc;
    logic        r_access_fault;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic [7:0]  w_sel_byte;
    logic [15:0] w_sel_half;
    logic [31:0] w_load_ext;
    logic [3:0]  w_lane_mask;
    logic [31:0] w_store_rep;
    logic [31:0] w_merged;

    assign w_accept = (r_state == S_IDLE) && req_valid;

    always_comb begin
        case (req_size)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = req_addr[0];
            2'b10:   w_misaligned = (req_addr[1:0] != 2'b00);
            default: w_misaligned = 1'b1;
        endcase
    end

`ifdef MAU_RANGE_CHECK_EN
    assign w_out_of_range = ((req_addr >> 2) >= (32'd1 << RAM_ADDR_WIDTH));
`else
    assign w_out_of_range = 1'b0;
`endif

    // Load path: pick the addressed lane out of the captured RAM word and extend it.
    assign w_sel_byte = 8'(mem_dout >> {r_addr[1:0], 3'b000});
    assign w_sel_half = r_addr[1] ? mem_dout[31:16] : mem_dout[15:0];

    always_comb begin
        case (r_size)
            2'b00:   w_load_ext = r_unsigned ? {24'h0, w_sel_byte}
                                             : {{24{w_sel_byte[7]}}, w_sel_byte};
            2'b01:   w_load_ext = r_unsigned ? {16'h0, w_sel_half}
                                             : {{16{w_sel_half[15]}}, w_sel_half};
            default: w_load_ext = mem_dout;
        endcase
    end

    // Store path: replicate the new data across lanes, then keep only the addressed one.
    always_comb begin
        w_lane_mask = 4'b0000;
        w_store_rep = r_wdata;
        case (r_size)
            2'b00: begin
                w_lane_mask[r_addr[1:0]] = 1'b1;
                w_store_rep = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_lane_mask = r_addr[1] ? 4'b1100 : 4'b0011;
                w_store_rep = {2{r_wdata[15:0]}};
            end
            default: w_lane_mask = 4'b1111;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign w_merged[8*gi +: 8] = w_lane_mask[gi] ? w_store_rep[8*gi +: 8]
                                                         : mem_dout[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_misaligned || w_out_of_range) begin
                        w_state_next = S_DONE;
                    end else if (req_we && (req_size == 2'b10)) begin
                        w_state_next = S_WR;
                    end else begin
                        w_state_next = S_RD;
                    end
                end
            end
            S_RD:    if (!mem_stall) w_state_next = S_CAP;
            S_CAP:   w_state_next = r_we ? S_WR : S_DONE;
            S_WR:    if (!mem_stall) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_din   = 32'h0;
        stall_out = 1'b0;
        case (r_state)
            S_IDLE: stall_out = req_valid;
            S_RD: begin
                mem_cs    = 1'b1;
                stall_out = 1'b1;
            end
            S_CAP: stall_out = 1'b1;
            S_WR: begin
                mem_cs    = 1'b1;
                mem_we    = 1'b1;
                mem_din   = r_wdata;
                stall_out = 1'b1;
            end
            default: stall_out = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we             <= 1'b0;
            r_size           <= 2'b00;
            r_unsigned       <= 1'b0;
            r_addr           <= 32'h0;
            r_wdata          <= 32'h0;
            r_done           <= 1'b0;
            r_rdata          <= 32'h0;
            r_misaligned_exc <= 1'b0;
            r_access_fault   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we       <= req_we;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
            end else if ((r_state == S_CAP) && r_we) begin
                r_wdata <= w_merged;
            end
            // Completion outputs are only non-zero for the single DONE cycle.
            r_done           <= (w_state_next == S_DONE);
            r_rdata          <= ((r_state == S_CAP) && !r_we) ? w_load_ext : 32'h0;
            r_misaligned_exc <= w_accept && w_misaligned;
            r_access_fault   <= w_accept && !w_misaligned && w_out_of_range;
        end
    end

    assign done           = r_done;
    assign rdata_out      = r_rdata;
    assign misaligned_exc = r_misaligned_exc;
    assign access_fault   = r_access_fault;
    assign mem_addr       = {2'b00, r_addr[31:2]};

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 32-word registered-read RAM model.
// Range expectations follow MAU_RANGE_CHECK_EN when the bench is built with it.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall_out;
    logic        done;
    logic [31:0] rdata_out;
    logic        misaligned_exc;
    logic        access_fault;
    logic        mem_cs;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_stall;
    logic        ram_init;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] ram [0:31];

    always #5 clk = ~clk;

    mem_access_unit #(.RAM_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall_out(stall_out), .done(done),
        .rdata_out(rdata_out), .misaligned_exc(misaligned_exc),
        .access_fault(access_fault), .mem_cs(mem_cs), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_stall(mem_stall)
    );

    // RAM: registered read, ignores accesses while stalled or beyond its 32 words.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int k = 0; k < 32; k++) ram[k] <= 32'h0;
            ram[0] <= 32'h01020304;
            ram[2] <= 32'h11223344;
            ram[3] <= 32'h8899AABB;
            ram[4] <= 32'hCAFEF00D;
            mem_dout <= 32'h0;
        end else if (mem_cs && !mem_stall) begin
            if (mem_addr < 32) begin
                if (mem_we) ram[mem_addr[4:0]] <= mem_din;
                else        mem_dout <= ram[mem_addr[4:0]];
            end else if (!mem_we) begin
                mem_dout <= 32'h0;
            end
        end
    end

    // Presents one request from a negedge, follows it to done and one cycle beyond.
    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int cycles, output logic [31:0] rd,
                           output logic exc, output logic fault,
                           output int n_rd, output int n_wr,
                           output logic [31:0] wr_addr, output logic [31:0] wr_din,
                           output logic acc_stall, output logic done_next);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        #1 acc_stall = stall_out;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wdata;
        cycles = 1; n_rd = 0; n_wr = 0; wr_addr = 32'h0; wr_din = 32'h0;
        while (!done && cycles < 20) begin
            if (mem_cs && !mem_we) n_rd++;
            if (mem_cs && mem_we) begin
                n_wr++; wr_addr = mem_addr; wr_din = mem_din;
            end
            @(negedge clk);
            cycles++;
        end
        rd = rdata_out; exc = misaligned_exc; fault = access_fault;
        $display("txn we=%0d size=%0d uns=%0d addr=%h wdata=%h cycles=%0d rdata=%h exc=%0d fault=%0d",
                 we, size, uns, addr, wdata, cycles, rd, exc, fault);
        @(negedge clk);
        done_next = done;
    endtask

    int          cyc;
    logic [31:0] rd;
    logic        exc, fault, acc_stall, done_next;
    int          n_rd, n_wr;
    logic [31:0] wr_addr, wr_din;

    task automatic test_reset();
        rst = 1'b1; ram_init = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; mem_stall = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; ram_init = 1'b0;
        @(negedge clk);
        vectors++;
        if ({done, mem_cs, mem_we, misaligned_exc, access_fault, stall_out} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctl got done=%b cs=%b we=%b exc=%b fault=%b stall=%b want all 0",
                     done, mem_cs, mem_we, misaligned_exc, access_fault, stall_out);
        end
        vectors++;
        if ({mem_addr, mem_din, rdata_out} !== 96'h0) begin
            miscompares++;
            $display("FAIL reset_data got addr=%h din=%h rdata=%h want 0", mem_addr, mem_din, rdata_out);
        end
    endtask

    task automatic test_load_ext();
        logic [1:0]  sz  [7] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
        logic        un  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] ad  [7] = '{32'h0D, 32'h0D, 32'h0E, 32'h0C, 32'h0C, 32'h0F, 32'h0C};
        logic [31:0] exp [7] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h0000AABB,
                                 32'hFFFFFFBB, 32'hFFFFFF88, 32'h8899AABB};
        for (int i = 0; i < 7; i++) begin
            run_req(1'b0, sz[i], un[i], ad[i], 32'h5A5A5A5A, cyc, rd, exc, fault,
                    n_rd, n_wr, wr_addr, wr_din, acc_stall, done_next);
            vectors++;
            if (cyc != 3) begin
                miscompares++;
                $display("FAIL load_latency[%0d] got %0d want 3", i, cyc);
            end
            vectors++;
            if (rd !== exp[i]) begin
                miscompares++;
                $display("FAIL load_rdata[%0d] got %h want %h", i, rd, exp[i]);
            end
            if (i == 0) begin
                vectors++;
                if (acc_stall !== 1'b1 || done_next !== 1'b0 || n_wr != 0 || n_rd != 1) begin
                    miscompares++;
                    $display("FAIL load_handshake got stall=%b done_next=%b rd=%0d wr=%0d want 1 0 1 0",
                             acc_stall, done_next, n_rd, n_wr);
                end
            end
        end
    endtask

    task automatic test_subword_store();
        run_req(1'b1, 2'b01, 1'b0, 32'h0E, 32'h00001234, cyc, rd, exc, fault,
                n_rd, n_wr, wr_addr, wr_din, acc_stall, done_next);
        vectors++;
        if (cyc != 4 || n_rd != 1 || n_wr != 1) begin
            miscompares++;
            $display("FAIL half_store_seq got cyc=%0d rd=%0d wr=%0d want 4 1 1", cyc, n_rd, n_wr);
        end
        vectors++;
        if (wr_addr !== 32'd3 || wr_din !== 32'h1234AABB || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL half_store_data got addr=%h din=%h rdata=%h want 3 1234aabb 0",
                     wr_addr, wr_din, rd);
        end
        run_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, cyc, rd, exc, fault,
                n_rd, n_wr, wr_addr, wr_din, acc_stall, done_next);
        vectors++;
        if (rd !== 32'h1234AABB) begin
            miscompares++;
            $display("FAIL half_store_readback got %h want 1234aabb", rd);
        end
        run_req(1'b1, 2'b00, 1'b0, 32'h09, 32'hABCDEF55, cyc, rd, exc, fault,
                n_rd, n_wr, wr_addr, wr_din, acc_stall, done_next);
        vectors++;
        if (cyc != 4 || wr_addr !== 32'd2 || wr_din !== 32'h11225544) begin
            miscompares++;
            $display("FAIL byte_store got cyc=%0d addr=%h din=%h want 4 2 11225544", cyc, wr_addr, wr_din);
        end
    endtask

    task automatic test_word_store();
        run_req(1'b1, 2'b10, 1'b0, 32'h14, 32'hCAFEBABE, cyc, rd, exc, fault,
                n_rd, n_wr, wr_addr, wr_din, acc_stall, done_next);
        vectors++;
        if (cyc != 2 || n_rd != 0 || n_wr != 1 || wr_addr !== 32'd5 || wr_din !== 32'hCAFEBABE) begin
            miscompares++;
            $display("FAIL word_store got cyc=%0d rd=%0d wr=%0d addr=%h din=%h want 2 0 1 5 cafebabe",
                     cyc, n_rd, n_wr, wr_addr, wr_din);
        end
        run_req(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, cyc, rd, exc, fault,
                n_rd, n_wr, wr_addr, wr_din, acc_stall, done_next);
        vectors++;
        if (rd !== 32'hFFFFCAFE) begin
            miscompares++;
            $display("FAIL word_store_readback got %h want ffffcafe", rd);
        end
    endtask

    task automatic test_misaligned();
        logic        we [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0]  sz [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        logic [31:0] ad [4] = '{32'h02, 32'h0D, 32'h0C, 32'h01};
        for (int i = 0; i < 4; i++) begin
            run_req(we[i], sz[i], 1'b0, ad[i], 32'hFFFFFFFF, cyc, rd, exc, fault,
                    n_rd, n_wr, wr_addr, wr_din, acc_stall, done_next);
            vectors++;
            if (cyc != 1 || exc !== 1'b1 || fault !== 1'b0 || rd !== 32'h0 || (n_rd + n_wr) != 0) begin
                miscompares++;
                $display("FAIL misaligned[%0d] got cyc=%0d exc=%b fault=%b rdata=%h ram_cycles=%0d want 1 1 0 0 0",
                         i, cyc, exc, fault, rd, n_rd + n_wr);
            end
        end
        run_req(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, cyc, rd, exc, fault,
                n_rd, n_wr, wr_addr, wr_din, acc_stall, done_next);
        vectors++;
        if (rd !== 32'h01020304 || exc !== 1'b0) begin
            miscompares++;
            $display("FAIL misaligned_no_write got %h exc=%b want 01020304 0", rd, exc);
        end
    endtask

    task automatic test_mem_stall();
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0; mem_stall = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_addr = 32'hFFFFFFF0;
        for (int c = 1; c <= 3; c++) begin
            vectors++;
            if (mem_cs !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'd4 || stall_out !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_rd[%0d] got cs=%b we=%b addr=%h stall=%b done=%b want 1 0 4 1 0",
                         c, mem_cs, mem_we, mem_addr, stall_out, done);
            end
            if (c == 3) mem_stall = 1'b0;
            @(negedge clk);
        end
        vectors++;
        if (mem_cs !== 1'b0 || stall_out !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_cap got cs=%b stall=%b done=%b want 0 1 0", mem_cs, stall_out, done);
        end
        @(negedge clk);
        $display("txn stalled word load addr=00000010 done=%0d rdata=%h", done, rdata_out);
        vectors++;
        if (done !== 1'b1 || rdata_out !== 32'hCAFEF00D || stall_out !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_done got done=%b rdata=%h stall=%b want 1 cafef00d 0",
                     done, rdata_out, stall_out);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_during_write();
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h08; req_wdata = 32'hDEADBEEF; mem_stall = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        vectors++;
        if (mem_we !== 1'b1 || mem_din !== 32'hDEADBEEF || mem_addr !== 32'd2) begin
            miscompares++;
            $display("FAIL rst_wr_pre got we=%b din=%h addr=%h want 1 deadbeef 2", mem_we, mem_din, mem_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        $display("txn word store deadbeef at 00000008 interrupted by reset");
        vectors++;
        if ({mem_cs, mem_we, done, stall_out, misaligned_exc, access_fault} !== 6'b0 ||
            {mem_addr, mem_din, rdata_out} !== 96'h0) begin
            miscompares++;
            $display("FAIL rst_wr_post got cs=%b we=%b done=%b stall=%b addr=%h din=%h rdata=%h want all 0",
                     mem_cs, mem_we, done, stall_out, mem_addr, mem_din, rdata_out);
        end
        rst = 1'b0; mem_stall = 1'b0;
        @(negedge clk);
        run_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, cyc, rd, exc, fault,
                n_rd, n_wr, wr_addr, wr_din, acc_stall, done_next);
        vectors++;
        if (rd !== 32'h11225544 || cyc != 3) begin
            miscompares++;
            $display("FAIL rst_wr_old got %h cyc=%0d want 11225544 3", rd, cyc);
        end
    endtask

    task automatic test_range();
        run_req(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, cyc, rd, exc, fault,
                n_rd, n_wr, wr_addr, wr_din, acc_stall, done_next);
`ifdef MAU_RANGE_CHECK_EN
        vectors++;
        if (cyc != 1 || fault !== 1'b1 || exc !== 1'b0 || n_rd != 0 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL range_fault got cyc=%0d fault=%b exc=%b rd_cycles=%0d rdata=%h want 1 1 0 0 0",
                     cyc, fault, exc, n_rd, rd);
        end
`else
        vectors++;
        if (cyc != 3 || fault !== 1'b0 || exc !== 1'b0 || n_rd != 1 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL range_nocheck got cyc=%0d fault=%b exc=%b rd_cycles=%0d rdata=%h want 3 0 0 1 0",
                     cyc, fault, exc, n_rd, rd);
        end
`endif
        run_req(1'b0, 2'b10, 1'b0, 32'h82, 32'h0, cyc, rd, exc, fault,
                n_rd, n_wr, wr_addr, wr_din, acc_stall, done_next);
        vectors++;
        if (cyc != 1 || exc !== 1'b1 || fault !== 1'b0) begin
            miscompares++;
            $display("FAIL range_priority got cyc=%0d exc=%b fault=%b want 1 1 0", cyc, exc, fault);
        end
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_subword_store();
        test_word_store();
        test_misaligned();
        test_mem_stall();
        test_reset_during_write();
        test_range();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
